// File: rtl/hazard_sequencer.sv
// hazard_sequencer: decode-side hazard controller for the 5-stage core.
// Detects load-use and control hazards, drives PC / IF-ID / ID-EX controls,
// and keeps a saturating stall counter plus a sticky control-wait timeout.
module hazard_sequencer #(
  parameter int LOAD_PENALTY = 1,   // 1..7 cycles held per load-use hazard
  parameter int CTRL_TIMEOUT = 15,  // 1..255 CTRL_WAIT cycles before timeout
  parameter int CNT_W        = 32   // width of stall_count
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [6:0]       id_opc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic             ex_resolve,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_count,
  output logic             timeout_err
);

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

  localparam logic [2:0] HOLD_INIT = 3'(LOAD_PENALTY - 1);
  localparam logic [7:0] TMO_LIMIT = 8'(CTRL_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN,
    ST_LOAD_HOLD,
    ST_CTRL_WAIT
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       tcnt_q, tcnt_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             timeout_err_q, timeout_err_d;

  logic load_use;
  logic ctrl;

  // Hazard detection on the decode-stage instruction against the EX load.
  always_comb begin
    load_use = id_valid && ex_is_load && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
    ctrl     = id_valid && ((id_opc == OPCODE_JAL) ||
                            (id_opc == OPCODE_JALR) ||
                            (id_opc == OPCODE_BRANCH));
  end

  // Next-state and pipeline controls from current state and live inputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    cnt_d         = cnt_q;
    tcnt_d        = tcnt_q;
    timeout_err_d = timeout_err_q;
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    ifid_flush    = 1'b0;
    idex_bubble   = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (load_use) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_bubble = 1'b1;
          if (LOAD_PENALTY > 1) begin
            state_d = ST_LOAD_HOLD;
            cnt_d   = HOLD_INIT;
          end
        end else if (ctrl) begin
          // The control instruction moves on to EX; the fetch behind it is
          // squashed until EX tells us where to go.
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          state_d    = ST_CTRL_WAIT;
          tcnt_d     = 8'd0;
        end
      end

      ST_LOAD_HOLD: begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
        if (cnt_q == 3'd1) begin
          state_d = ST_RUN;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end

      ST_CTRL_WAIT: begin
        pc_en       = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (ex_resolve) begin
          // The datapath PC mux is valid this cycle, so let the PC load it.
          pc_en   = 1'b1;
          state_d = ST_RUN;
          tcnt_d  = 8'd0;
        end else if (tcnt_q + 8'd1 == TMO_LIMIT) begin
          timeout_err_d = 1'b1;
          state_d       = ST_RUN;
          tcnt_d        = 8'd0;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end

      default: state_d = ST_RUN;
    endcase

    // Reset holds the pipeline frozen and filled with NOPs.
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  // Saturating count of cycles the PC was held.
  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_en && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_ONE;
    end
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= 3'd0;
      tcnt_q        <= 8'd0;
      stall_count_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tcnt_q        <= tcnt_d;
      stall_count_q <= stall_count_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign busy        = rst_n && (state_q != ST_RUN);
  assign stall_count = stall_count_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Bench for hazard_sequencer: two instances (different parameters) share one
// stimulus stream; each is compared every cycle against a cycle-count model.
module tb_hazard_sequencer;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_uses_rs1, id_uses_rs2, ex_is_load, ex_resolve;
  logic [6:0] id_opc;
  logic [4:0] id_rs1, id_rs2, ex_rd;

  logic        a_pc, a_ifen, a_flush, a_bub, a_busy, a_terr;
  logic [31:0] a_sc;
  logic        b_pc, b_ifen, b_flush, b_bub, b_busy, b_terr;
  logic [3:0]  b_sc;

  int n_pass = 0;
  int n_total = 0;

  // Model state per instance: remaining forced load-stall cycles, cycles
  // spent waiting for a resolve (-1 = not waiting), sticky error, stall total.
  int     lp[2]  = '{1, 3};
  int     tmo[2] = '{15, 4};
  int     cw[2]  = '{32, 4};
  int     hold_left[2];
  int     wait_age[2];
  bit     terr_m[2];
  longint scount_m[2];

  always #5 clk = ~clk;

  hazard_sequencer #(.LOAD_PENALTY(1), .CTRL_TIMEOUT(15), .CNT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opc(id_opc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_resolve(ex_resolve), .pc_en(a_pc), .ifid_en(a_ifen),
    .ifid_flush(a_flush), .idex_bubble(a_bub), .busy(a_busy),
    .stall_count(a_sc), .timeout_err(a_terr));

  hazard_sequencer #(.LOAD_PENALTY(3), .CTRL_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opc(id_opc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
    .id_uses_rs2(id_uses_rs2), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .ex_resolve(ex_resolve), .pc_en(b_pc), .ifid_en(b_ifen),
    .ifid_flush(b_flush), .idex_bubble(b_bub), .busy(b_busy),
    .stall_count(b_sc), .timeout_err(b_terr));

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit lu_now();
    return id_valid && ex_is_load && ex_rd != 0 &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic bit ctrl_now();
    return id_valid && (id_opc == OPC_JAL || id_opc == OPC_JALR ||
                        id_opc == OPC_BRANCH);
  endfunction

  function automatic bit exp_pc(int k);
    if (!rst_n) return 1'b0;
    if (hold_left[k] > 0) return 1'b0;
    if (wait_age[k] >= 0) return ex_resolve;
    return !(lu_now() || ctrl_now());
  endfunction

  task automatic model_reset(int k);
    hold_left[k] = 0;
    wait_age[k]  = -1;
    terr_m[k]    = 1'b0;
    scount_m[k]  = 0;
  endtask

  // Compare one instance's outputs with the model for the current cycle.
  task automatic check_dut(int k, logic pc, logic ifen, logic flush, logic bub,
                           logic bsy, logic [63:0] sc, logic te);
    bit e_ifen, e_flush, e_bub, chk_ifen;
    string p;
    p = (k == 0) ? "a" : "b";
    chk_ifen = 1'b1;
    if (!rst_n) begin
      e_ifen = 0; e_flush = 1; e_bub = 1;
    end else if (hold_left[k] > 0) begin
      e_ifen = 0; e_flush = 0; e_bub = 1;
    end else if (wait_age[k] >= 0) begin
      e_ifen = 0; e_flush = 1; e_bub = 1; chk_ifen = 0;
    end else if (lu_now()) begin
      e_ifen = 0; e_flush = 0; e_bub = 1;
    end else if (ctrl_now()) begin
      e_ifen = 1; e_flush = 1; e_bub = 0;
    end else begin
      e_ifen = 1; e_flush = 0; e_bub = 0;
    end
    check({p, ".pc_en"}, 64'(pc), 64'(exp_pc(k)));
    if (chk_ifen) check({p, ".ifid_en"}, 64'(ifen), 64'(e_ifen));
    check({p, ".ifid_flush"}, 64'(flush), 64'(e_flush));
    check({p, ".idex_bubble"}, 64'(bub), 64'(e_bub));
    check({p, ".busy"}, 64'(bsy),
          64'(rst_n && (hold_left[k] > 0 || wait_age[k] >= 0)));
    check({p, ".stall_count"}, sc, 64'(scount_m[k]));
    check({p, ".timeout_err"}, 64'(te), 64'(terr_m[k]));
  endtask

  // Advance the model across one rising edge using the inputs seen there.
  task automatic model_step(int k);
    longint sat;
    bit pc;
    if (!rst_n) begin
      model_reset(k);
      return;
    end
    pc  = exp_pc(k);
    sat = (64'sd1 <<< cw[k]) - 1;
    if (!pc && scount_m[k] < sat) scount_m[k]++;
    if (hold_left[k] > 0) begin
      hold_left[k]--;
    end else if (wait_age[k] >= 0) begin
      if (ex_resolve) wait_age[k] = -1;
      else begin
        wait_age[k]++;
        if (wait_age[k] == tmo[k]) begin
          terr_m[k]   = 1'b1;
          wait_age[k] = -1;
        end
      end
    end else if (lu_now()) begin
      hold_left[k] = lp[k] - 1;
    end else if (ctrl_now()) begin
      wait_age[k] = 0;
    end
  endtask

  task automatic cycle();
    #3;
    check_dut(0, a_pc, a_ifen, a_flush, a_bub, a_busy, 64'(a_sc), a_terr);
    check_dut(1, b_pc, b_ifen, b_flush, b_bub, b_busy, 64'(b_sc), b_terr);
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_opc = OPC_OP; id_rs1 = 0; id_rs2 = 0;
    id_uses_rs1 = 0; id_uses_rs2 = 0; ex_is_load = 0; ex_rd = 0;
    ex_resolve = 0;
  endtask

  task automatic set_random();
    logic [6:0] opcs[6];
    opcs = '{OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_LOAD, OPC_OP, OPC_OPIMM};
    id_valid    = ($urandom_range(0, 3) != 0);
    id_opc      = opcs[$urandom_range(0, 5)];
    id_rs1      = 5'($urandom_range(0, 3));
    id_rs2      = 5'($urandom_range(0, 3));
    id_uses_rs1 = 1'($urandom);
    id_uses_rs2 = 1'($urandom);
    ex_is_load  = 1'($urandom);
    ex_rd       = 5'($urandom_range(0, 3));
    ex_resolve  = ($urandom_range(0, 3) == 0);
  endtask

  task automatic set_load_use(logic [4:0] rd, logic [6:0] opc);
    set_idle();
    id_valid = 1; id_opc = opc; id_rs1 = 5; id_uses_rs1 = 1;
    ex_is_load = 1; ex_rd = rd;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    set_idle();
    rst_n = 0;
    #1;

    // Reset held for 3 cycles with random inputs.
    repeat (3) begin
      set_random();
      cycle();
    end
    check("rst.a_stall_count", 64'(a_sc), 64'd0);

    // Release: no hazard means the PC advances immediately.
    rst_n = 1;
    set_idle();
    #1;
    check("release.a_pc_en", 64'(a_pc), 64'd1);
    cycle();

    // Load-use on rs1 (rd=5), then the same with rd=0 which is no hazard.
    set_load_use(5'd5, OPC_OP);
    cycle();
    check("lu1.a_stall_count", 64'(a_sc), 64'd1);
    set_idle();
    repeat (3) cycle();
    set_load_use(5'd0, OPC_OP);
    #1;
    check("lu_rd0.a_pc_en", 64'(a_pc), 64'd1);
    cycle();
    set_idle();
    cycle();

    // BRANCH in ID, resolve two cycles later.
    set_idle();
    id_valid = 1; id_opc = OPC_BRANCH;
    cycle();
    set_idle();
    cycle();
    ex_resolve = 1;
    cycle();
    ex_resolve = 0;
    repeat (2) cycle();

    // Load-use together with JAL: load stall first, then the control wait.
    set_load_use(5'd5, OPC_JAL);
    cycle();
    ex_is_load = 0;
    repeat (3) cycle();
    set_idle();
    ex_resolve = 1;
    cycle();
    ex_resolve = 0;
    repeat (2) cycle();

    // JALR with no resolve: instance b times out after 4 wait cycles.
    set_idle();
    id_valid = 1; id_opc = OPC_JALR;
    cycle();
    set_idle();
    repeat (3) cycle();
    check("tmo.b_before", 64'(b_terr), 64'd0);
    cycle();
    check("tmo.b_set", 64'(b_terr), 64'd1);
    repeat (14) cycle();
    check("tmo.b_sticky", 64'(b_terr), 64'd1);

    // Continuous load-use for 20 cycles saturates the 4-bit counter.
    set_load_use(5'd5, OPC_OP);
    repeat (20) cycle();
    check("sat.b_stall_count", 64'(b_sc), 64'd15);
    set_idle();
    repeat (3) cycle();

    // Randomized traffic with occasional resets.
    repeat (600) begin
      set_random();
      rst_n = ($urandom_range(0, 39) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Clocked pipeline-hazard controller for the 5-stage RISC-V core. Sits beside the decode stage.
- Watches the decode-stage opcode and operands and the execute-stage load destination and branch-resolve strobe.
- Sequences PC hold, IF/ID hold and flush, and ID/EX bubble insertion for load-use and control hazards.
- Also keeps a saturating stall-cycle counter and a control-resolve timeout flag.

Parameters:
- LOAD_PENALTY, 1, number of cycles held per load-use hazard (1..7).
- CTRL_TIMEOUT, 15, maximum CTRL_WAIT cycles before timeout_err is set (1..255).
- CNT_W, 32, width of stall_count.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- id_valid  in  1  the decode stage holds a valid instruction.
- id_opc  in  7  opcode of the decode-stage instruction (OPCODE_* constants).
- id_rs1  in  5  rs1 index of the decode-stage instruction.
- id_rs2  in  5  rs2 index of the decode-stage instruction.
- id_uses_rs1  in  1  the decode-stage instruction reads rs1.
- id_uses_rs2  in  1  the decode-stage instruction reads rs2.
- ex_is_load  in  1  the execute-stage instruction is a LOAD.
- ex_rd  in  5  destination register of the execute-stage instruction.
- ex_resolve  in  1  one-cycle strobe: the branch/jump in EX has resolved and the datapath PC mux is valid.
- pc_en  out  1  PC register write enable.
- ifid_en  out  1  IF/ID register write enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_bubble  out  1  load a NOP into ID/EX.
- busy  out  1  state is not RUN.
- stall_count  out  CNT_W  saturating count of cycles with pc_en=0.
- timeout_err  out  1  sticky; set when a control wait exceeds CTRL_TIMEOUT.

Behaviour:
- Reset (rst_n=0 at a clock edge): state goes to RUN; counters clear; stall_count=0; timeout_err=0. While rst_n is low, outputs are forced to pc_en=0, ifid_en=0, ifid_flush=1, idex_bubble=1, busy=0. Reset mid-sequence aborts any LOAD_HOLD or CTRL_WAIT with no residual effect.
- Hazard definitions:
  - load_use = id_valid & ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - ctrl = id_valid & id_opc in {OPCODE_JAL, OPCODE_JALR, OPCODE_BRANCH}.
- Outputs are combinational from the current state and inputs (zero-latency response). State and counters are registered.
- RUN:
  - No hazard: pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
  - load_use (has priority over ctrl): pc_en=0, ifid_en=0, idex_bubble=1. If LOAD_PENALTY>1, go to LOAD_HOLD with cnt=LOAD_PENALTY-1; otherwise stay in RUN.
  - ctrl without load_use: pc_en=0, ifid_en=1, ifid_flush=1, idex_bubble=0 (the control instruction advances to EX). Go to CTRL_WAIT with tcnt=0.
  - ex_resolve in RUN is ignored.
- LOAD_HOLD:
  - Outputs: pc_en=0, ifid_en=0, idex_bubble=1.
  - Each cycle cnt decrements; at cnt==1 the state returns to RUN. The load_use input is not re-evaluated while in LOAD_HOLD.
- CTRL_WAIT:
  - Outputs: pc_en=0, ifid_flush=1, idex_bubble=1 (ID is empty).
  - On ex_resolve: pc_en=1 that same cycle (the PC takes the target or PC+4 from the datapath), ifid_flush=1; go to RUN.
  - Without ex_resolve, tcnt increments. When tcnt reaches CTRL_TIMEOUT, set timeout_err and go to RUN.
  - id_valid and id_opc are ignored in this state.
- stall_count increments on every non-reset cycle with pc_en=0 and saturates at all-ones (no wrap).
- busy = (state != RUN).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random inputs -> pc_en=0, idex_bubble=1, ifid_flush=1, stall_count=0, timeout_err=0. Release -> pc_en=1 with no hazard.
- Load-use with LOAD_PENALTY=1: ex_is_load=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle -> exactly 1 cycle of pc_en=0 and idex_bubble=1; stall_count=1. Same stimulus with ex_rd=0 -> no stall.
- Load-use with LOAD_PENALTY=3 -> pc_en=0 for 3 consecutive cycles, busy=1 on cycles 2-3, then RUN.
- BRANCH in ID, ex_resolve asserted 2 cycles later -> pc_en sequence 0,0,1; ifid_flush=1 on all three cycles; busy deasserts after the resolve edge.
- Simultaneous load_use and JAL opcode with a matching rs1 -> load stall taken first. Next cycle (load_use clear) the ctrl sequence starts.
- CTRL_TIMEOUT=4, JALR with no ex_resolve -> timeout_err rises after 4 CTRL_WAIT cycles and stays set until reset. Separately, preload stall_count near all-ones (CNT_W=4) and stall 20 cycles -> stall_count holds at 15.
